ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 keyboard receiver, next generation of the board's scan-code front end.
//  - Samples ps2_clk/ps2_data, validates 11-bit frames and decodes E0/F0 prefixes into key events.
//  - Buffers events in a FIFO drained by a valid/ready consumer (display or MMIO bridge).
//  - Adds frame timeout, error and overflow reporting, and a make-event counter.
// PARAMETERS
//  FIFO_DEPTH      8      events buffered; power of two, >=2
//  SYNC_STAGES     3      flops on ps2_clk/ps2_data synchronisers; >=2
//  TIMEOUT_CYCLES  50000  clk cycles with no ps2_clk fall mid-frame before the frame is aborted
//  CNT_W           8      width of key_cnt and err_cnt
// PORTS
//  clk        in   1      system clock; only clock in the block
//  reset      in   1      asynchronous, active-high reset
//  ps2_clk    in   1      raw PS/2 clock from pad
//  ps2_data   in   1      raw PS/2 data from pad
//  out_valid  out  1      FIFO head holds an event
//  out_ready  in   1      consumer takes head when out_valid & out_ready
//  out_code   out  8      head scan code (prefixes stripped)
//  out_brk    out  1      head is a release (F0 preceded)
//  out_ext    out  1      head is extended (E0 preceded)
//  key_cnt    out  CNT_W  number of make events pushed, wraps
//  err_cnt    out  CNT_W  parity/start/stop/timeout errors, saturates at all-ones
//  overflow   out  1      sticky: an event was dropped because FIFO full
//  ovf_clr    in   1      clears overflow; loses to a same-cycle drop (drop wins)
// BEHAVIOUR
//  Reset: all outputs 0 (out_valid=0, counters=0, overflow=0); FSM IDLE, flags cleared, FIFO empty.
//    Reset mid-frame discards the partial frame.
//  Sampling: falling edge = last two ps2_clk sync stages equal 1 then 0; ps2_data sampled from same-depth sync.
//  Frame FSM, advancing on sampling edges only:
//    IDLE -(edge, data=0)-> SHIFT; an edge with data=1 in IDLE is ignored (no error).
//    SHIFT: capture 8 data bits LSB first, then parity, bit counter 0..8.
//    SHIFT -(9th edge)-> STOP.
//    STOP -(edge)-> IDLE; frame good iff data=1 and odd parity over 8 data bits + parity bit.
//  Bad frame: drop byte, err_cnt++ (saturating), prefix flags untouched.
//  Timeout: in SHIFT/STOP, TIMEOUT_CYCLES clk without edge -> IDLE, err_cnt++. Counter reloads on each edge.
//  Prefix decode on good byte:
//    E0 -> ext_flag=1, no push.
//    F0 -> brk_flag=1, no push.
//    Any other byte -> push {ext_flag, brk_flag, code}, clear both flags.
//    Repeated E0/F0 keep their flags set.
//  Latency: good stop-bit edge at cycle N, push at N+1, out_valid=1 at N+2 when FIFO was empty.
//  FIFO: first-word fall-through, registered head.
//    Push accepted if !full, or if full with a pop in the same cycle.
//    Otherwise drop, overflow<=1, key_cnt unchanged.
//    Pop when empty is ignored; simultaneous push+pop when empty: push only.
//    Pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally.
//  key_cnt increments only on accepted pushes with brk=0; wraps at 2^CNT_W.
//  out_* stable while out_valid & !out_ready.
// STRUCTURE
//  ps2_pkg.vh (shared): PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_EVT_W=10, FSM state encodings.
//  Sub-module ps2_evt_fifo: PS2_EVT_W-wide sync FIFO, DEPTH parameter, push/pop/full/empty.
//  Top holds synchronisers, edge detect, frame FSM, timeout counter, prefix decoder, counters.
// TESTING
//  Send frame 0x1C, good parity -> one event code=1C brk=0 ext=0; key_cnt=1.
//  Send E0,F0,75 -> single event code=75 ext=1 brk=1; key_cnt unchanged; no event for prefixes.
//  Frame 0x1C with bad parity, then 0x1C with stop=0 -> no events; err_cnt=2.
//  Start bit plus 4 data bits, hold ps2_clk high TIMEOUT_CYCLES+1 -> err_cnt=1.
//    Following good frame 0x32 decodes correctly.
//  out_ready=0, send FIFO_DEPTH+1 makes -> FIFO_DEPTH events kept in order, overflow=1.
//    ovf_clr pulse then clears overflow.
//  Assert reset mid-frame after 5 bits -> outputs 0; next full frame 0x1C decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants, FSM encoding and event layout for the PS/2 keyboard receiver.
// Both the frame front end and the event FIFO import these definitions.
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         PS2_EVT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_keyboard_rx_evt_fifo.sv
// First-word fall-through event FIFO; the head reads straight out of the storage flops.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module ps2_evt_fifo
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [PS2_EVT_W-1:0] din_i,
    input  logic                 pop_i,
    output logic [PS2_EVT_W-1:0] dout_o,
    output logic                 accept_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_q, wr_d;
    logic [AW:0]          rd_q, rd_d;
    logic [PS2_EVT_W-1:0] mem_q [DEPTH];
    logic                 do_pop;

    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop   = pop_i && !empty_o;
    assign accept_o = push_i && (!full_o || do_pop);
    assign wr_d     = accept_o ? wr_q + 1'b1 : wr_q;
    assign rd_d     = do_pop ? rd_q + 1'b1 : rd_q;
    assign dout_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage carries data only, so it is left out of reset; empty gates the head.
    always_ff @(posedge clk_i) begin
        if (accept_o) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the pad lines, validates 11-bit frames,
// folds E0/F0 prefixes into key events and queues them for a valid/ready consumer.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic             out_brk,
    output logic             out_ext,
    output logic [CNT_W-1:0] key_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    ps2_state_e             state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [8:0]             shreg_q, shreg_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic                   push_q, push_d;
    ps2_evt_t               evt_q, evt_d;
    logic [CNT_W-1:0]       key_cnt_q, err_cnt_q;
    logic                   ovf_q;

    logic                   fall, data_s, timeout;
    logic                   frame_done, frame_good, to_err;
    logic                   fifo_accept, fifo_full, fifo_empty;
    logic [PS2_EVT_W-1:0]   fifo_dout;
    ps2_evt_t               head;

    // Falling edge: older stage still high while the newer stage already reads low.
    assign fall    = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
        frame_good = 1'b0;
        to_err     = 1'b0;
        to_cnt_d   = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    shreg_d = {data_s, shreg_q[8:1]};
                    if (bit_cnt_q == 4'd8) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    to_err  = 1'b1;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                    frame_good = data_s && (^shreg_q);
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    to_err  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prefix decode: flags survive bad frames and are consumed by the next plain byte.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        push_d = 1'b0;
        evt_d  = evt_q;
        if (frame_good) begin
            if (shreg_q[7:0] == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q[7:0] == PS2_BREAK) begin
                brk_d = 1'b1;
            end else begin
                push_d = 1'b1;
                evt_d  = '{ext: ext_q, brk: brk_q, code: shreg_q[7:0]};
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '0;
            data_sync_q <= '1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            key_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            if ((frame_done && !frame_good) || to_err) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
            if (fifo_accept && !evt_q.brk) begin
                key_cnt_q <= key_cnt_q + 1'b1;
            end
            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (push_q && !fifo_accept) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        evt_q   <= evt_d;
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_q),
        .din_i   (evt_q),
        .pop_i   (out_valid && out_ready),
        .dout_o  (fifo_dout),
        .accept_o(fifo_accept),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head      = ps2_evt_t'(fifo_dout);
    assign out_valid = !fifo_empty;
    assign out_code  = head.code;
    assign out_brk   = head.brk;
    assign out_ext   = head.ext;
    assign key_cnt   = key_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed frame table, timeout/overflow/reset sequences,
// then random byte streams checked against a queue-based event model.
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 8;
    localparam int SYNC  = 3;
    localparam int TO    = 64;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset, ps2_clk, ps2_data, out_ready, ovf_clr;
    logic          out_valid, out_brk, out_ext, overflow;
    logic [7:0]    out_code;
    logic [CW-1:0] key_cnt, err_cnt;

    ps2_keyboard_rx #(
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_brk(out_brk), .out_ext(out_ext), .key_cnt(key_cnt), .err_cnt(err_cnt),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        bit         has_evt;
        logic [9:0] evt;
        int         key;
        int         err;
    } vec_t;

    vec_t       vt [15];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] got_q [$];
    logic [9:0] exp_q [$];
    int         rd_i = 0;
    bit         m_ext, m_brk, m_ovf;
    int         m_key, m_err;
    bit         rand_rdy = 1'b0;
    bit         rdy_force = 1'b1;

    // Consumer side: every handshake is logged in order.
    always @(negedge clk) begin
        if (reset) got_q.delete();
        else if (out_valid && out_ready) got_q.push_back({out_ext, out_brk, out_code});
    end

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic expect_evt(input string n, input logic [9:0] e);
        int t = 0;
        while (got_q.size() <= rd_i && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() <= rd_i) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no_event required=%0h", n, e);
        end else begin
            chk(n, got_q[rd_i], e);
            rd_i++;
        end
    endtask

    // Reference model: acts on whole decoded bytes, FIFO occupancy = accepted - consumed.
    task automatic model_frame(input logic [7:0] c, input bit good);
        if (!good) begin
            if (m_err < (1 << CW) - 1) m_err++;
        end else if (c == 8'hE0) begin
            m_ext = 1'b1;
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() - got_q.size() < DEPTH) begin
                exp_q.push_back({m_ext, m_brk, c});
                if (!m_brk) m_key = (m_key + 1) % (1 << CW);
            end else begin
                m_ovf = 1'b1;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk) ps2_data = b;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input bit bp, input bit bs, input int nbits);
        logic [10:0] bits;
        bits = {~bs, (~^c) ^ bp, c, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        if (nbits == 11) model_frame(c, !bp && !bs);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        rd_i  = 0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        m_key = 0;
        m_err = 0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_code"}, {out_ext, out_brk, out_code}, 0);
        chk({tag, "_key"}, key_cnt, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ovf_clr = 1'b0;
        clear_model();
        vt[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1, 0};
        vt[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1, 0};
        vt[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1, 0};
        vt[3]  = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h375, 1, 0};
        vt[4]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1, 1};
        vt[5]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000, 1, 2};
        vt[6]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 10'h05A, 2, 2};
        vt[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 2, 2};
        vt[8]  = '{8'h74, 1'b0, 1'b0, 1'b1, 10'h274, 3, 2};
        vt[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 3, 2};
        vt[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 3, 2};
        vt[11] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h11C, 3, 2};
        vt[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 3, 2};
        vt[13] = '{8'h33, 1'b1, 1'b0, 1'b0, 10'h000, 3, 3};
        vt[14] = '{8'h6B, 1'b0, 1'b0, 1'b1, 10'h26B, 4, 3};

        repeat (5) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            send_frame(vt[i].code, vt[i].bad_par, vt[i].bad_stop, 11);
            if (vt[i].has_evt) expect_evt($sformatf("vec%0d_evt", i), vt[i].evt);
            else chk($sformatf("vec%0d_noevt", i), got_q.size() - rd_i, 0);
            chk($sformatf("vec%0d_key", i), key_cnt, vt[i].key);
            chk($sformatf("vec%0d_err", i), err_cnt, vt[i].err);
        end

        // Frame abandoned after the start bit and four data bits.
        send_frame(8'h0F, 1'b0, 1'b0, 5);
        repeat (TO + 10) @(negedge clk);
        if (m_err < (1 << CW) - 1) m_err++;
        chk("timeout_err", err_cnt, 4);
        send_frame(8'h32, 1'b0, 1'b0, 11);
        expect_evt("after_timeout_evt", 10'h032);
        chk("after_timeout_key", key_cnt, 5);
        chk("after_timeout_err", err_cnt, 4);

        // Stalled consumer: DEPTH+1 makes, the last one is dropped.
        rdy_force = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 11);
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_head_stable", {out_ext, out_brk, out_code}, 10'h010);
        chk("ovf_key", key_cnt, (5 + DEPTH) % (1 << CW));
        chk("ovf_nopop", got_q.size() - rd_i, 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf   = 1'b0;
        @(negedge clk);
        chk("ovf_clr", overflow, 0);
        rdy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) expect_evt($sformatf("drain%0d", i), 10'h010 + 10'(i));
        repeat (10) @(negedge clk);
        chk("drain_extra", got_q.size() - rd_i, 0);
        chk("drain_valid", out_valid, 0);

        // Reset in the middle of a frame.
        send_frame(8'hA5, 1'b0, 1'b0, 5);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("midreset");
        reset = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        chk_zero_outputs("postreset");
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        expect_evt("postreset_evt", 10'h01C);
        chk("postreset_key", key_cnt, 1);

        // Random stream with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] c;
            int         r;
            bit         bp, bs;
            r  = int'($urandom_range(0, 7));
            c  = 8'($urandom);
            if (c == 8'hE0 || c == 8'hF0) c = 8'h2A;
            if (r == 0) c = 8'hE0;
            if (r == 1) c = 8'hF0;
            bp = ($urandom_range(0, 5) == 0);
            bs = !bp && ($urandom_range(0, 7) == 0);
            send_frame(c, bp, bs, 11);
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        repeat (20) @(negedge clk);
        chk("rand_key", key_cnt, m_key);
        chk("rand_err", err_cnt, m_err);
        chk("rand_ovf", overflow, m_ovf);
        chk("rand_nevt", got_q.size(), exp_q.size());
        for (int i = rd_i; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rand_evt%0d", i), got_q[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
